// File: rtl/pixel_pkg.sv
// Shared constants for the pixel block: FSM state encoding and control-register base.
// Pure declarations, no logic, no latency, no backpressure.
// Imported by the Wishbone initiator and its compare/counter helper.
package pixel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [31:0] PIXEL_CTRL_BASE = 32'h3000_0000;
    localparam int unsigned CNT_W           = 8;

endpackage

// File: rtl/pixel_wb_master_if.sv
// Command/response handshake plus Wishbone classic initiator signals for pixel_wb_master.
// Wires only, no latency; backpressure is cmd_ready_o and wbm_ack_i.
// master = the initiator block, slave = the sequencer/responder side.
interface pixel_wb_master_if #(
    parameter int ADDR_W = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic              cmd_poll_i;
    logic [ADDR_W-1:0] cmd_adr_i;
    logic [31:0]       cmd_dat_i;
    logic [31:0]       cmd_mask_i;
    logic [3:0]        cmd_sel_i;

    logic              rsp_valid_o;
    logic [31:0]       rsp_dat_o;
    logic              rsp_err_o;
    logic [7:0]        rsp_cnt_o;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [31:0]       wbm_dat_o;
    logic              wbm_ack_i;
    logic [31:0]       wbm_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_poll_i, cmd_adr_i, cmd_dat_i, cmd_mask_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_cnt_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_poll_i, cmd_adr_i, cmd_dat_i, cmd_mask_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_cnt_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/pixel_wb_poll_cmp.sv
// Masked read-data compare plus saturating attempt counter for poll commands.
// Compare is combinational; counter updates one cycle after clr/inc.
// No backpressure: the caller decides when to clear and increment.
module pixel_wb_poll_cmp
    import pixel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rd_dat,
    input  logic [31:0]      cmp_dat,
    input  logic [31:0]      mask,
    input  logic             clr,
    input  logic             inc,
    output logic             match,
    output logic [CNT_W-1:0] cnt_q,
    output logic [CNT_W-1:0] cnt_nxt
);

    assign match   = ((rd_dat & mask) == (cmp_dat & mask));
    assign cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: rtl/pixel_wb_master.sv
// Single-command Wishbone classic initiator (read, write, bounded read-poll); bus-hang timeout under PIXEL_WB_MASTER_TIMEOUT_EN.
// Latency: stb one cycle after handshake, response pulse the cycle after ack.
// Backpressure: cmd_ready_o only in IDLE; no queueing, one response per command.
module pixel_wb_master
    import pixel_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int POLL_MAX    = 255,
    parameter int POLL_GAP    = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    pixel_wb_master_if.master     bus
);

    // Attempt counter is 8 bits wide, so the poll bound cannot usefully exceed 255.
    localparam int          POLL_LIM   = (POLL_MAX > 255) ? 255 : POLL_MAX;
    localparam logic [7:0]  POLL_LIM8  = POLL_LIM[7:0];
    localparam int          GAP_W      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int          GAP_LAST_I = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_LAST_I[GAP_W-1:0];

    state_t            state_q, state_d;
    logic              we_q, poll_q;
    logic [ADDR_W-1:0] adr_q;
    logic [31:0]       dat_q, mask_q;
    logic [3:0]        sel_q;
    logic [GAP_W-1:0]  gap_cnt_q;

    logic [31:0]       rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic [7:0]        rsp_cnt_q, rsp_cnt_d;

    logic              cap, cnt_clr, cnt_inc, rsp_load, to_hit;
    logic              match;
    logic [7:0]        cnt_q, cnt_nxt;

    pixel_wb_poll_cmp u_poll_cmp (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .rd_dat  (bus.wbm_dat_i),
        .cmp_dat (dat_q),
        .mask    (mask_q),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .match   (match),
        .cnt_q   (cnt_q),
        .cnt_nxt (cnt_nxt)
    );

`ifdef PIXEL_WB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int TO_LAST_I = TIMEOUT_CYC - 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];
    logic [TO_W-1:0] to_cnt_q;

    // Cleared outside BUS and on every ack so each bus attempt gets a fresh budget.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q != ST_BUS || bus.wbm_ack_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
    assign to_hit = (state_q == ST_BUS) && !bus.wbm_ack_i && (to_cnt_q == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cap       = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        rsp_load  = 1'b0;
        rsp_dat_d = 32'h0;
        rsp_err_d = 1'b0;
        rsp_cnt_d = cnt_nxt;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    cap     = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus.wbm_ack_i) begin
                    cnt_inc   = 1'b1;
                    rsp_dat_d = we_q ? 32'h0 : bus.wbm_dat_i;
                    if (we_q || !poll_q || match) begin
                        rsp_load = 1'b1;
                        state_d  = ST_RESP;
                    end else if (cnt_nxt >= POLL_LIM8) begin
                        rsp_load  = 1'b1;
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = (POLL_GAP == 0) ? ST_BUS : ST_GAP;
                    end
                end else if (to_hit) begin
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                    rsp_cnt_d = cnt_q;
                    state_d   = ST_RESP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_BUS;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            poll_q    <= 1'b0;
            adr_q     <= '0;
            dat_q     <= 32'h0;
            mask_q    <= 32'h0;
            sel_q     <= 4'h0;
            gap_cnt_q <= '0;
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b0;
            rsp_cnt_q <= 8'h0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + 1'b1 : '0;
            if (cap) begin
                we_q   <= bus.cmd_we_i;
                poll_q <= bus.cmd_poll_i & ~bus.cmd_we_i;
                adr_q  <= bus.cmd_adr_i;
                dat_q  <= bus.cmd_dat_i;
                mask_q <= bus.cmd_mask_i;
                sel_q  <= bus.cmd_sel_i;
            end
            if (rsp_load) begin
                rsp_dat_q <= rsp_dat_d;
                rsp_err_q <= rsp_err_d;
                rsp_cnt_q <= rsp_cnt_d;
            end
        end
    end

    assign bus.cmd_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_cnt_o   = rsp_cnt_q;
    assign bus.wbm_cyc_o   = (state_q == ST_BUS);
    assign bus.wbm_stb_o   = (state_q == ST_BUS);
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;

endmodule
